memoria32_data: RTL and testbench



---
 rtl/memoria32_data.sv | 51 +++++
 tb/tb_memoria32_data.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memoria32_data.sv
// 32-bit word-organised data RAM: synchronous write on rising Clk, combinational read.
// Byte addresses are reduced to a word index; contents clear asynchronously on reset.
module memoria32_data #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 128
) (
  input  logic              Clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] raddress,
  input  logic [ADDR_W-1:0] waddress,
  input  logic [31:0]       Datain,
  input  logic              Wr,
  output logic [31:0]       Dataout
);

  localparam int WORD_IDX_W = $clog2(DEPTH_WORDS);

  logic [31:0]           mem_q [DEPTH_WORDS];
  logic [31:0]           mem_d [DEPTH_WORDS];
  logic [WORD_IDX_W-1:0] ridx;
  logic [WORD_IDX_W-1:0] widx;

  // Byte-lane bits and everything above the array size are intentionally dropped.
  logic unused_addr_bits;

  assign ridx = raddress[WORD_IDX_W+1:2];
  assign widx = waddress[WORD_IDX_W+1:2];

  assign unused_addr_bits = ^{raddress[ADDR_W-1:WORD_IDX_W+2], raddress[1:0],
                              waddress[ADDR_W-1:WORD_IDX_W+2], waddress[1:0]};

  always_comb begin
    mem_d = mem_q;
    if (Wr) begin
      mem_d[widx] = Datain;
    end
  end

  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem_q[i] <= 32'h0000_0000;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign Dataout = mem_q[ridx];

endmodule

// File: tb/tb_memoria32_data.sv
// Self-checking bench for memoria32_data: directed scenarios plus randomized
// traffic compared against a behavioural array model indexed by byte address.
module tb_memoria32_data;

  localparam int DEPTH = 128;

  logic        Clk;
  logic        rst_n;
  logic [31:0] raddress;
  logic [31:0] waddress;
  logic [31:0] Datain;
  logic        Wr;
  logic [31:0] Dataout;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model_mem [DEPTH];

  memoria32_data #(
    .ADDR_W      (32),
    .DEPTH_WORDS (DEPTH)
  ) dut (
    .Clk      (Clk),
    .rst_n    (rst_n),
    .raddress (raddress),
    .waddress (waddress),
    .Datain   (Datain),
    .Wr       (Wr),
    .Dataout  (Dataout)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // A byte address names the word holding it; the array repeats every DEPTH*4 bytes.
  function automatic int word_of(input logic [31:0] a);
    return int'((a / 32'd4) % DEPTH);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    return model_mem[word_of(a)];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge Clk);
    waddress = a;
    Datain   = d;
    Wr       = 1'b1;
    @(posedge Clk);
    if (rst_n) model_mem[word_of(a)] = d;
    #1;
    Wr = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] addrs [3];
    addrs[0] = 32'h000; addrs[1] = 32'h004; addrs[2] = 32'h1FC;
    @(negedge Clk);
    #2 rst_n = 1'b0;
    model_clear();
    #1;
    raddress = 32'h000;
    #1;
    checks++;
    if (Dataout !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_held addr=%h got=%h exp=%h", raddress, Dataout, 32'h0);
    end
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      raddress = addrs[i];
      #1;
      checks++;
      if (Dataout !== 32'h0) begin
        failures++;
        $display("[TB] FAIL reset_read addr=%h got=%h exp=%h", raddress, Dataout, 32'h0);
      end
    end
  endtask

  task automatic test_basic();
    logic [31:0] addrs [4];
    addrs[0] = 32'h010; addrs[1] = 32'h011; addrs[2] = 32'h013; addrs[3] = 32'h014;
    do_write(32'h010, 32'hDEADBEEF);
    for (int i = 0; i < 4; i++) begin
      raddress = addrs[i];
      #1;
      checks++;
      if (Dataout !== ((i < 3) ? 32'hDEADBEEF : 32'h0)) begin
        failures++;
        $display("[TB] FAIL basic_read addr=%h got=%h exp=%h", raddress, Dataout,
                 (i < 3) ? 32'hDEADBEEF : 32'h0);
      end
    end
  endtask

  task automatic test_wr_gating();
    @(negedge Clk);
    waddress = 32'h020;
    Datain   = 32'h12345678;
    Wr       = 1'b0;
    @(posedge Clk);
    #1;
    raddress = 32'h020;
    #1;
    checks++;
    if (Dataout !== model_read(32'h020) || Dataout !== 32'h0) begin
      failures++;
      $display("[TB] FAIL wr_gating got=%h exp=%h", Dataout, 32'h0);
    end
  endtask

  task automatic test_same_word();
    do_write(32'h008, 32'h11111111);
    do_write(32'h00C, 32'h33333333);
    @(negedge Clk);
    raddress = 32'h008;
    waddress = 32'h008;
    Datain   = 32'h22222222;
    Wr       = 1'b1;
    #1;
    checks++;
    if (Dataout !== 32'h11111111) begin
      failures++;
      $display("[TB] FAIL rdw_before got=%h exp=%h", Dataout, 32'h11111111);
    end
    @(posedge Clk);
    model_mem[word_of(32'h008)] = 32'h22222222;
    #1;
    Wr = 1'b0;
    checks++;
    if (Dataout !== 32'h22222222) begin
      failures++;
      $display("[TB] FAIL rdw_after got=%h exp=%h", Dataout, 32'h22222222);
    end
    // Neighbouring word read while its neighbour is being written.
    @(negedge Clk);
    raddress = 32'h00C;
    waddress = 32'h008;
    Datain   = 32'h44444444;
    Wr       = 1'b1;
    @(posedge Clk);
    model_mem[word_of(32'h008)] = 32'h44444444;
    #1;
    Wr = 1'b0;
    checks++;
    if (Dataout !== 32'h33333333) begin
      failures++;
      $display("[TB] FAIL rdw_other got=%h exp=%h", Dataout, 32'h33333333);
    end
  endtask

  task automatic test_wrap();
    do_write(32'h204, 32'hCAFEF00D);
    raddress = 32'h004;
    #1;
    checks++;
    if (Dataout !== 32'hCAFEF00D) begin
      failures++;
      $display("[TB] FAIL wrap got=%h exp=%h", Dataout, 32'hCAFEF00D);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_v;
    int          errs;
    errs = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge Clk);
      Wr       = ($urandom_range(0, 3) != 0);
      waddress = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 1023));
      Datain   = $urandom;
      if ($urandom_range(0, 2) == 0)
        raddress = {$urandom_range(0, 7) == 0 ? 23'($urandom) : waddress[31:9],
                    waddress[8:2], 2'($urandom)};
      else
        raddress = $urandom;
      #1;
      exp_v = model_read(raddress);
      checks++;
      if (Dataout !== exp_v) begin
        failures++;
        if (errs++ < 10)
          $display("[TB] FAIL rand_pre addr=%h got=%h exp=%h", raddress, Dataout, exp_v);
      end
      @(posedge Clk);
      if (Wr) model_mem[word_of(waddress)] = Datain;
      #1;
      exp_v = model_read(raddress);
      checks++;
      if (Dataout !== exp_v) begin
        failures++;
        if (errs++ < 10)
          $display("[TB] FAIL rand_post addr=%h got=%h exp=%h", raddress, Dataout, exp_v);
      end
      Wr = 1'b0;
    end
    for (int w = 0; w < DEPTH; w++) begin
      raddress = 32'(w * 4);
      #1;
      checks++;
      if (Dataout !== model_mem[w]) begin
        failures++;
        if (errs++ < 10)
          $display("[TB] FAIL rand_scan word=%0d got=%h exp=%h", w, Dataout, model_mem[w]);
      end
    end
  endtask

  task automatic test_async_reset();
    do_write(32'h030, 32'hA5A5A5A5);
    do_write(32'h034, 32'h5A5A5A5A);
    do_write(32'h1F8, 32'h0BADF00D);
    raddress = 32'h034;
    #1;
    checks++;
    if (Dataout !== 32'h5A5A5A5A) begin
      failures++;
      $display("[TB] FAIL pre_reset got=%h exp=%h", Dataout, 32'h5A5A5A5A);
    end
    @(negedge Clk);
    #2 rst_n = 1'b0;
    model_clear();
    #1;
    checks++;
    if (Dataout !== 32'h0) begin
      failures++;
      $display("[TB] FAIL async_clear got=%h exp=%h", Dataout, 32'h0);
    end
    waddress = 32'h040;
    Datain   = 32'hFFFFFFFF;
    Wr       = 1'b1;
    @(posedge Clk);
    #1;
    Wr = 1'b0;
    raddress = 32'h040;
    #1;
    checks++;
    if (Dataout !== 32'h0) begin
      failures++;
      $display("[TB] FAIL wr_in_reset got=%h exp=%h", Dataout, 32'h0);
    end
    @(negedge Clk);
    #2 rst_n = 1'b1;
    for (int w = 0; w < DEPTH; w++) begin
      raddress = 32'(w * 4);
      #1;
      checks++;
      if (Dataout !== model_mem[w]) begin
        failures++;
        $display("[TB] FAIL post_reset_scan word=%0d got=%h exp=%h", w, Dataout, model_mem[w]);
      end
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    raddress = 32'h0;
    waddress = 32'h0;
    Datain   = 32'h0;
    Wr       = 1'b0;
    model_clear();
    #12 rst_n = 1'b1;
    test_reset();
    test_basic();
    test_wr_gating();
    test_same_word();
    test_wrap();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
